imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
Shares the single-port instruction memory in the IF stage between two requesters: the fetch unit (read-only) and the program loader/debug port (read or write).
- Drives the memory's addr/Din/we/re pins directly.
- Returns registered read data to whichever requester won.
- The loader has priority. A starvation counter guarantees forward progress for fetch.

Parameters:
STARVE_MAX, 4, consecutive fetch-denied cycles after which fetch is forced to win one grant (legal range 1..15).
CNT_W, 4, starvation counter width; must hold STARVE_MAX.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
if_req  input  1  fetch requests a read this cycle
if_addr  input  32  fetch word address (PC in words)
if_gnt  output  1  fetch owns memory this cycle (combinational)
if_valid  output  1  registered: if_rdata holds the word granted last cycle
if_rdata  output  32  registered fetch read data
ld_req  input  1  loader requests an access this cycle
ld_we  input  1  1 = write, 0 = read
ld_addr  input  32  loader word address
ld_wdata  input  32  loader write data
ld_gnt  output  1  loader owns memory this cycle (combinational)
ld_valid  output  1  registered: loader access granted last cycle completed
ld_rdata  output  32  registered loader read data (0 after a write)
mem_addr  output  32  to memory addr
mem_din  output  32  to memory Din
mem_we  output  1  to memory we
mem_re  output  1  to memory re
mem_out  input  32  from memory out (combinational read)

Behaviour:
- Reset values (asynchronous, on rst_n low):
  - if_valid = 0, ld_valid = 0, if_rdata = 0, ld_rdata = 0.
  - Starvation counter = 0, state = NORMAL.
  - Grants are forced to 0 while rst_n is low.
- Memory pins when idle (no grant): mem_re = 0, mem_we = 0, mem_addr = 0, mem_din = 0. The memory then drives z, which must never be captured.
- State machine, 2 states:
  - NORMAL: if both requesters are active, the loader wins.
  - STARVE: entered when the counter reaches STARVE_MAX. If if_req is asserted, fetch wins. After one fetch grant, clear the counter and return to NORMAL. If if_req drops while in STARVE, return to NORMAL with the counter cleared.
- Starvation counter:
  - Increments each cycle in which if_req = 1 and if_gnt = 0.
  - Clears on any if_gnt, and in any cycle with if_req = 0.
  - Saturates at STARVE_MAX.
- Single requester always wins in the same cycle. Grants are mutually exclusive; at most one is high.
- Granted cycle N, memory pins:
  - mem_addr = winner address, mem_re = 1.
  - mem_we = ld_we only for a loader grant.
  - mem_din = ld_wdata on a loader write, else 0.
- Latency, same granted cycle N:
  - On the posedge ending N, a read captures mem_out into the winner's rdata register.
  - The winner's valid is high for exactly cycle N+1; valid is a single-cycle pulse, never held.
  - A loader write commits on that same edge; ld_rdata = 0 and ld_valid = 1 in N+1.
- Write-then-fetch coherence: a fetch granted in cycle N+1 to a word written in cycle N returns the new data. No bypass is needed because the write has already committed.
- Requesters hold req/addr until they see gnt. After gnt, a requester may change or drop them next cycle.
- Addresses pass through untouched; the memory uses bits [7:0].
- Reset mid-operation: pending valids clear immediately. A grant in progress is lost; no write occurs if rst_n is low at the clock edge.
- Non-winner rdata registers hold their previous value.

Decomposition:
- Package imem_pkg:
  - IMEM_WORDS = 256, IMEM_IDX_W = 8.
  - Arbiter state enum {NORMAL, STARVE}.
  - Grant-source enum {SRC_NONE, SRC_IF, SRC_LD}.
- Sub-module imem_starve_cnt: counter, saturation and threshold flag. Parameterised by STARVE_MAX/CNT_W.
- The rest (grant logic, pin mux, response registers) stays in imem_arbiter.

Test Plan:
1. Reset release, fetch only: if_req = 1, if_addr = 0 -> if_gnt = 1 same cycle; next cycle if_valid = 1, if_rdata = 0x00302083 (lw x1,3(x0)); ld_valid stays 0.
2. Loader write then fetch: cycle N ld_req = 1, ld_we = 1, ld_addr = 9, ld_wdata = 0x00108093. Cycle N+1 fetch if_addr = 9 -> if_rdata = 0x00108093 in N+2; ld_valid = 1 and ld_rdata = 0 in N+1.
3. Contention with STARVE_MAX = 4: ld_req and if_req held high for 20 cycles -> grant pattern LD,LD,LD,LD,IF repeating; if_gnt never low for more than 4 consecutive cycles.
4. Simultaneous requests with counter 0: loader read of addr 22 wins -> ld_rdata = 0x00210633 next cycle; if_gnt = 0 and counter = 1.
5. Idle cycles: no requests -> mem_re = 0, mem_we = 0; both valids 0; rdata registers unchanged from the previous test.
6. Reset mid-operation: assert rst_n low between clock edges while if_valid = 1 and a loader write to addr 5 is granted -> valids drop immediately, and memory[5] is unchanged after release (still 0x00508533).

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and sizing for the instruction-memory arbiter slice.
// The memory itself is word-addressed and only decodes the low IMEM_IDX_W bits.
package imem_pkg;

  localparam int IMEM_WORDS = 256;
  localparam int IMEM_IDX_W = 8;

  typedef enum logic {
    NORMAL = 1'b0,
    STARVE = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_IF   = 2'd1,
    SRC_LD   = 2'd2
  } grant_src_t;

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of the fetch, loader and memory-pin signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface imem_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;

  logic        ld_req;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt;
  logic        ld_valid;
  logic [31:0] ld_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_out;

  modport slave (
    input  if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_out,
    output if_gnt, if_valid, if_rdata, ld_gnt, ld_valid, ld_rdata,
    output mem_addr, mem_din, mem_we, mem_re
  );

  modport master (
    output if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_out,
    input  if_gnt, if_valid, if_rdata, ld_gnt, ld_valid, ld_rdata,
    input  mem_addr, mem_din, mem_we, mem_re
  );

endinterface

// File: rtl/imem_starve_cnt.sv
// Saturating count of consecutive denied fetch cycles.
// thresh looks at the next count so the arbiter can switch state on the same edge.
module imem_starve_cnt
  import imem_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             thresh
);

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt;
    if (clr)
      cnt_next = '0;
    else if (inc && (cnt != MAX_VAL))
      cnt_next = cnt + 1'b1;
  end

  assign thresh = (cnt_next == MAX_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else
      cnt <= cnt_next;
  end

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single-port instruction memory between fetch and the loader.
// Loader wins by default; after STARVE_MAX denied fetch cycles fetch gets one grant.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input logic           clk,
  input logic           rst_n,
  imem_arbiter_if.slave bus
);

  arb_state_t       state;
  arb_state_t       state_next;
  grant_src_t       src;
  logic             cnt_inc;
  logic             cnt_clr;
  logic             cnt_thresh;
  logic [CNT_W-1:0] cnt;

  // Grants are purely combinational and forced off while reset is held.
  always_comb begin
    src = SRC_NONE;
    if (rst_n) begin
      if ((state == STARVE) && bus.if_req)
        src = SRC_IF;
      else if (bus.ld_req)
        src = SRC_LD;
      else if (bus.if_req)
        src = SRC_IF;
    end
  end

  assign bus.if_gnt = (src == SRC_IF);
  assign bus.ld_gnt = (src == SRC_LD);

  assign cnt_inc = bus.if_req && (src != SRC_IF);
  assign cnt_clr = !bus.if_req || (src == SRC_IF);

  imem_starve_cnt #(
    .STARVE_MAX(STARVE_MAX),
    .CNT_W     (CNT_W)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .cnt   (cnt),
    .thresh(cnt_thresh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= NORMAL;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      NORMAL: if (cnt_thresh) state_next = STARVE;
      STARVE: if (!bus.if_req || (src == SRC_IF)) state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
  end

  // Idle pins are all zero so the memory's floating output is never sampled.
  always_comb begin
    bus.mem_addr = '0;
    bus.mem_din  = '0;
    bus.mem_we   = 1'b0;
    bus.mem_re   = 1'b0;
    case (src)
      SRC_IF: begin
        bus.mem_addr = bus.if_addr;
        bus.mem_re   = 1'b1;
      end
      SRC_LD: begin
        bus.mem_addr = bus.ld_addr;
        bus.mem_re   = 1'b1;
        bus.mem_we   = bus.ld_we;
        bus.mem_din  = bus.ld_we ? bus.ld_wdata : 32'h0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.if_valid <= 1'b0;
      bus.if_rdata <= '0;
    end else begin
      bus.if_valid <= (src == SRC_IF);
      if (src == SRC_IF)
        bus.if_rdata <= bus.mem_out;
    end
  end

  // A loader write reports zero data; the write itself commits on this same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ld_valid <= 1'b0;
      bus.ld_rdata <= '0;
    end else begin
      bus.ld_valid <= (src == SRC_LD);
      if (src == SRC_LD)
        bus.ld_rdata <= bus.ld_we ? 32'h0 : bus.mem_out;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural 256-word memory.
// Inputs change and outputs are sampled around the falling edge.
module tb_imem_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [31:0] mem [0:255];
  logic        mem_loaded = 1'b0;

  imem_arbiter_if bus();

  imem_arbiter #(.STARVE_MAX(4), .CNT_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: combinational read, write on the rising edge; floats when not read.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      mem[0]     <= 32'h0030_2083;
      mem[5]     <= 32'h0050_8533;
      mem[22]    <= 32'h0021_0633;
      mem_loaded <= 1'b1;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_din;
    end
  end

  assign bus.mem_out = bus.mem_re ? mem[bus.mem_addr[7:0]] : 32'hzzzz_zzzz;

  task automatic idle_inputs();
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.ld_req   = 1'b0;
    bus.ld_we    = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.if_req = 1'b1;
    bus.ld_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({bus.if_gnt, bus.ld_gnt} !== 2'b00) begin
      bad++; $display("[TB] FAIL reset_gnt got=%b want=00", {bus.if_gnt, bus.ld_gnt});
    end
    total++;
    if ({bus.if_valid, bus.ld_valid} !== 2'b00) begin
      bad++; $display("[TB] FAIL reset_valid got=%b want=00", {bus.if_valid, bus.ld_valid});
    end
    total++;
    if (bus.if_rdata !== 32'h0 || bus.ld_rdata !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_rdata got=%h/%h want=0/0", bus.if_rdata, bus.ld_rdata);
    end
    total++;
    if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_pins got re=%b we=%b addr=%h want 0", bus.mem_re, bus.mem_we, bus.mem_addr);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_only();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'd0;
    #1;
    total++;
    if (bus.if_gnt !== 1'b1 || bus.ld_gnt !== 1'b0) begin
      bad++; $display("[TB] FAIL fetch_gnt got if=%b ld=%b want if=1 ld=0", bus.if_gnt, bus.ld_gnt);
    end
    total++;
    if (bus.mem_re !== 1'b1 || bus.mem_addr !== 32'd0) begin
      bad++; $display("[TB] FAIL fetch_pins got re=%b addr=%h want re=1 addr=0", bus.mem_re, bus.mem_addr);
    end
    @(negedge clk);
    total++;
    if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h0030_2083) begin
      bad++; $display("[TB] FAIL fetch_data got v=%b d=%h want v=1 d=00302083", bus.if_valid, bus.if_rdata);
    end
    total++;
    if (bus.ld_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL fetch_ldvalid got=%b want=0", bus.ld_valid);
    end
    idle_inputs();
    @(negedge clk);
    total++;
    if (bus.if_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL fetch_pulse got=%b want=0", bus.if_valid);
    end
  endtask

  task automatic test_write_then_fetch();
    bus.ld_req   = 1'b1;
    bus.ld_we    = 1'b1;
    bus.ld_addr  = 32'd9;
    bus.ld_wdata = 32'h0010_8093;
    #1;
    total++;
    if (bus.ld_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'd9 || bus.mem_din !== 32'h0010_8093) begin
      bad++; $display("[TB] FAIL wr_pins got gnt=%b we=%b addr=%h din=%h want 1/1/9/00108093",
                      bus.ld_gnt, bus.mem_we, bus.mem_addr, bus.mem_din);
    end
    @(negedge clk);
    total++;
    if (bus.ld_valid !== 1'b1 || bus.ld_rdata !== 32'h0) begin
      bad++; $display("[TB] FAIL wr_resp got v=%b d=%h want v=1 d=0", bus.ld_valid, bus.ld_rdata);
    end
    idle_inputs();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'd9;
    @(negedge clk);
    total++;
    if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h0010_8093) begin
      bad++; $display("[TB] FAIL wr_coherent got v=%b d=%h want v=1 d=00108093", bus.if_valid, bus.if_rdata);
    end
    total++;
    if (bus.ld_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL wr_ldpulse got=%b want=0", bus.ld_valid);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_contention();
    int run_len;
    bit want_if;
    run_len = 0;
    bus.ld_req  = 1'b1;
    bus.ld_we   = 1'b0;
    bus.ld_addr = 32'd1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'd2;
    for (int k = 0; k < 20; k++) begin
      #1;
      want_if = ((k % 5) == 4);
      total++;
      if (bus.if_gnt !== want_if || bus.ld_gnt !== !want_if) begin
        bad++; $display("[TB] FAIL contend_c%0d got if=%b ld=%b want if=%b", k, bus.if_gnt, bus.ld_gnt, want_if);
      end
      run_len = (bus.if_gnt === 1'b1) ? 0 : run_len + 1;
      if (run_len > 4) begin
        total++; bad++;
        $display("[TB] FAIL contend_starve c%0d got run=%0d want<=4", k, run_len);
      end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    bus.ld_req  = 1'b1;
    bus.ld_we   = 1'b0;
    bus.ld_addr = 32'd22;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'd3;
    #1;
    total++;
    if (bus.ld_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin
      bad++; $display("[TB] FAIL simul_gnt got ld=%b if=%b want ld=1 if=0", bus.ld_gnt, bus.if_gnt);
    end
    @(negedge clk);
    total++;
    if (bus.ld_valid !== 1'b1 || bus.ld_rdata !== 32'h0021_0633) begin
      bad++; $display("[TB] FAIL simul_data got v=%b d=%h want v=1 d=00210633", bus.ld_valid, bus.ld_rdata);
    end
    total++;
    if (dut.u_starve.cnt !== 4'd1) begin
      bad++; $display("[TB] FAIL simul_cnt got=%0d want=1", dut.u_starve.cnt);
    end
    idle_inputs();
  endtask

  task automatic test_idle();
    #1;
    total++;
    if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_din !== 32'h0) begin
      bad++; $display("[TB] FAIL idle_pins got re=%b we=%b addr=%h din=%h want 0",
                      bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_din);
    end
    repeat (2) @(negedge clk);
    total++;
    if (bus.if_valid !== 1'b0 || bus.ld_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL idle_valid got if=%b ld=%b want 0/0", bus.if_valid, bus.ld_valid);
    end
    total++;
    if (bus.if_rdata !== 32'hA000_0002 || bus.ld_rdata !== 32'h0021_0633) begin
      bad++; $display("[TB] FAIL idle_hold got if=%h ld=%h want a0000002/00210633", bus.if_rdata, bus.ld_rdata);
    end
  endtask

  task automatic test_reset_midop();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'd0;
    @(negedge clk);
    total++;
    if (bus.if_valid !== 1'b1) begin
      bad++; $display("[TB] FAIL midrst_pre got=%b want=1", bus.if_valid);
    end
    idle_inputs();
    bus.ld_req   = 1'b1;
    bus.ld_we    = 1'b1;
    bus.ld_addr  = 32'd5;
    bus.ld_wdata = 32'hBAD0_BAD0;
    #1;
    total++;
    if (bus.ld_gnt !== 1'b1) begin
      bad++; $display("[TB] FAIL midrst_gnt got=%b want=1", bus.ld_gnt);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (bus.if_valid !== 1'b0 || bus.if_rdata !== 32'h0 || bus.ld_gnt !== 1'b0 || bus.mem_we !== 1'b0) begin
      bad++; $display("[TB] FAIL midrst_drop got v=%b d=%h gnt=%b we=%b want 0", bus.if_valid, bus.if_rdata,
                      bus.ld_gnt, bus.mem_we);
    end
    @(negedge clk);
    total++;
    if (bus.ld_valid !== 1'b0 || mem[5] !== 32'h0050_8533) begin
      bad++; $display("[TB] FAIL midrst_nowrite got v=%b mem5=%h want v=0 mem5=00508533", bus.ld_valid, mem[5]);
    end
    idle_inputs();
    rst_n = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'd5;
    @(negedge clk);
    total++;
    if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h0050_8533) begin
      bad++; $display("[TB] FAIL midrst_read got v=%b d=%h want v=1 d=00508533", bus.if_valid, bus.if_rdata);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fetch_only();
    test_write_then_fetch();
    test_contention();
    test_simultaneous();
    test_idle();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
